tile_scheduler: RTL

- Sequences one GEMM job across the systolic core.
- Consumes the CSR start/abort pulses and the M/N/K and Tm/Tn/Tk configuration.
- Walks the tile space in order m (outer), n, k (inner). For each tile it issues a load, then a compute, then swaps ping-pong banks.
- Produces the busy, done_tile pulse and rd-bank indications that the CSR block mirrors back to the host.

---
 rtl/accel_pkg.sv | 24 ++
 rtl/tile_index_counter.sv | 72 +++++++
 rtl/tile_scheduler.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/accel_pkg.sv
// ============================================================================
// accel_pkg
// Shared scheduler state encoding and default widths for the GEMM datapath.
// Revision: 1.0
// ============================================================================
`default_nettype none

package accel_pkg;

    localparam int DIM_W_DEF = 32;
    localparam int CNT_W_DEF = 32;

    typedef enum logic [2:0] {
        SCH_IDLE    = 3'd0,
        SCH_LOAD    = 3'd1,
        SCH_COMPUTE = 3'd2,
        SCH_WAIT    = 3'd3,
        SCH_ADVANCE = 3'd4,
        SCH_FINISH  = 3'd5
    } sched_state_e;

endpackage

`default_nettype wire

// File: rtl/tile_index_counter.sv
// ============================================================================
// tile_index_counter
// Nested k (inner) / n / m (outer) tile offset stepper with wrap flags.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tile_index_counter
    import accel_pkg::*;
#(
    parameter int DIM_W = DIM_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             step,
    input  logic [DIM_W-1:0] dim_m,
    input  logic [DIM_W-1:0] dim_n,
    input  logic [DIM_W-1:0] dim_k,
    input  logic [DIM_W-1:0] tile_m,
    input  logic [DIM_W-1:0] tile_n,
    input  logic [DIM_W-1:0] tile_k,
    output logic [DIM_W-1:0] m_idx,
    output logic [DIM_W-1:0] n_idx,
    output logic [DIM_W-1:0] k_idx,
    output logic             last_k,
    output logic             last_tile
);

    // One extra bit keeps offsets near 2^DIM_W from wrapping in the compare.
    logic [DIM_W:0] w_m_sum;
    logic [DIM_W:0] w_n_sum;
    logic [DIM_W:0] w_k_sum;
    logic           w_m_more;
    logic           w_n_more;
    logic           w_k_more;

    assign w_m_sum  = {1'b0, m_idx} + {1'b0, tile_m};
    assign w_n_sum  = {1'b0, n_idx} + {1'b0, tile_n};
    assign w_k_sum  = {1'b0, k_idx} + {1'b0, tile_k};
    assign w_m_more = w_m_sum < {1'b0, dim_m};
    assign w_n_more = w_n_sum < {1'b0, dim_n};
    assign w_k_more = w_k_sum < {1'b0, dim_k};

    assign last_k    = !w_k_more;
    assign last_tile = !w_k_more && !w_n_more && !w_m_more;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            m_idx <= '0;
            n_idx <= '0;
            k_idx <= '0;
        end else if (step) begin
            if (w_k_more) begin
                k_idx <= w_k_sum[DIM_W-1:0];
            end else begin
                k_idx <= '0;
                if (w_n_more) begin
                    n_idx <= w_n_sum[DIM_W-1:0];
                end else begin
                    n_idx <= '0;
                    if (w_m_more) begin
                        m_idx <= w_m_sum[DIM_W-1:0];
                    end
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/tile_scheduler.sv
// ============================================================================
// tile_scheduler
// Sequences one GEMM job tile by tile: load, compute, bank swap, advance.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tile_scheduler
    import accel_pkg::*;
#(
    parameter int DIM_W = DIM_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_pulse,
    input  logic             abort_pulse,
    input  logic [DIM_W-1:0] M,
    input  logic [DIM_W-1:0] N,
    input  logic [DIM_W-1:0] K,
    input  logic [DIM_W-1:0] Tm,
    input  logic [DIM_W-1:0] Tn,
    input  logic [DIM_W-1:0] Tk,
    output logic             load_req,
    input  logic             load_done,
    output logic             tile_start,
    input  logic             tile_done,
    output logic [DIM_W-1:0] m_idx,
    output logic [DIM_W-1:0] n_idx,
    output logic [DIM_W-1:0] k_idx,
    output logic [DIM_W-1:0] tm_eff,
    output logic [DIM_W-1:0] tn_eff,
    output logic [DIM_W-1:0] tk_eff,
    output logic             first_k,
    output logic             last_k,
    output logic             bank_sel_rd_A,
    output logic             bank_sel_rd_B,
    output logic             busy,
    output logic             done_tile_pulse,
    output logic             done_job_pulse,
    output logic [CNT_W-1:0] tiles_done
);

    sched_state_e     r_state;
    sched_state_e     w_next_state;

    logic [DIM_W-1:0] r_dim_m;
    logic [DIM_W-1:0] r_dim_n;
    logic [DIM_W-1:0] r_dim_k;
    logic [DIM_W-1:0] r_tile_m;
    logic [DIM_W-1:0] r_tile_n;
    logic [DIM_W-1:0] r_tile_k;

    logic             w_busy;
    logic             w_load_req;
    logic             w_tile_start;
    logic             w_start_ok;
    logic             w_tile_ok;
    logic             w_step;
    logic             w_zero_cfg;
    logic             w_last_k;
    logic             w_last_tile;
    logic [DIM_W-1:0] w_m_rem;
    logic [DIM_W-1:0] w_n_rem;
    logic [DIM_W-1:0] w_k_rem;

    assign w_zero_cfg = (M == '0) || (N == '0) || (K == '0) ||
                        (Tm == '0) || (Tn == '0) || (Tk == '0);
    assign w_start_ok = (r_state == SCH_IDLE) && start_pulse && !abort_pulse;
    assign w_tile_ok  = (r_state == SCH_WAIT) && tile_done && !abort_pulse;
    assign w_step     = (r_state == SCH_ADVANCE) && !abort_pulse;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= SCH_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_busy       = 1'b0;
        w_load_req   = 1'b0;
        w_tile_start = 1'b0;
        case (r_state)
            SCH_IDLE: begin
                if (w_start_ok) begin
                    w_next_state = w_zero_cfg ? SCH_FINISH : SCH_LOAD;
                end
            end
            SCH_LOAD: begin
                w_busy     = 1'b1;
                w_load_req = 1'b1;
                if (abort_pulse) begin
                    w_next_state = SCH_IDLE;
                end else if (load_done) begin
                    w_next_state = SCH_COMPUTE;
                end
            end
            SCH_COMPUTE: begin
                w_busy       = 1'b1;
                w_tile_start = 1'b1;
                w_next_state = abort_pulse ? SCH_IDLE : SCH_WAIT;
            end
            SCH_WAIT: begin
                w_busy = 1'b1;
                if (abort_pulse) begin
                    w_next_state = SCH_IDLE;
                end else if (tile_done) begin
                    w_next_state = SCH_ADVANCE;
                end
            end
            SCH_ADVANCE: begin
                w_busy = 1'b1;
                if (abort_pulse) begin
                    w_next_state = SCH_IDLE;
                end else begin
                    w_next_state = w_last_tile ? SCH_FINISH : SCH_LOAD;
                end
            end
            SCH_FINISH: begin
                w_next_state = SCH_IDLE;
            end
            default: begin
                w_next_state = SCH_IDLE;
            end
        endcase
    end

    assign busy       = w_busy;
    assign load_req   = w_load_req;
    assign tile_start = w_tile_start;

    // Shadow configuration, completion counters and bank selects.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dim_m         <= '0;
            r_dim_n         <= '0;
            r_dim_k         <= '0;
            r_tile_m        <= '0;
            r_tile_n        <= '0;
            r_tile_k        <= '0;
            tiles_done      <= '0;
            bank_sel_rd_A   <= 1'b0;
            bank_sel_rd_B   <= 1'b0;
            done_tile_pulse <= 1'b0;
            done_job_pulse  <= 1'b0;
        end else begin
            done_tile_pulse <= w_tile_ok;
            done_job_pulse  <= (r_state == SCH_FINISH) && !abort_pulse;
            if (w_start_ok) begin
                r_dim_m    <= M;
                r_dim_n    <= N;
                r_dim_k    <= K;
                r_tile_m   <= Tm;
                r_tile_n   <= Tn;
                r_tile_k   <= Tk;
                tiles_done <= '0;
            end
            if (w_tile_ok) begin
                tiles_done    <= tiles_done + CNT_W'(1);
                bank_sel_rd_A <= !bank_sel_rd_A;
                bank_sel_rd_B <= !bank_sel_rd_B;
            end
        end
    end

    tile_index_counter #(
        .DIM_W (DIM_W)
    ) u_index (
        .clk       (clk),
        .rst       (rst),
        .clear     (w_start_ok),
        .step      (w_step),
        .dim_m     (r_dim_m),
        .dim_n     (r_dim_n),
        .dim_k     (r_dim_k),
        .tile_m    (r_tile_m),
        .tile_n    (r_tile_n),
        .tile_k    (r_tile_k),
        .m_idx     (m_idx),
        .n_idx     (n_idx),
        .k_idx     (k_idx),
        .last_k    (w_last_k),
        .last_tile (w_last_tile)
    );

    // Offsets never exceed the dimension while a tile is live, so no underflow.
    assign w_m_rem = r_dim_m - m_idx;
    assign w_n_rem = r_dim_n - n_idx;
    assign w_k_rem = r_dim_k - k_idx;
    assign tm_eff  = (r_tile_m < w_m_rem) ? r_tile_m : w_m_rem;
    assign tn_eff  = (r_tile_n < w_n_rem) ? r_tile_n : w_n_rem;
    assign tk_eff  = (r_tile_k < w_k_rem) ? r_tile_k : w_k_rem;

    // Flags only mean something while a job is running; keep them low when idle.
    assign first_k = w_busy && (k_idx == '0);
    assign last_k  = w_busy && w_last_k;

endmodule

`default_nettype wire
